// File: rtl/scaler_v_mc.sv
// Vertical linear down-scaler: each output line blends two adjacent input lines
// through a one-line buffer; multi-channel beats, fixed 4-cycle latency, sticky error flags.
module scaler_v_mc #(
    parameter int LINE_IN_SIZE_MAX = 1024,
    parameter int LINE_STEP        = 128,
    parameter int PIXEL_WIDTH      = 8,
    parameter int CH_COUNT         = 3,
    parameter int COE_WIDTH        = 8,
    parameter int STEP_WIDTH       = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [15:0]                     line_in_size,
    input  logic [STEP_WIDTH-1:0]           scale_step,
    input  logic                            bypass_i,
    input  logic [CH_COUNT*PIXEL_WIDTH-1:0] di_i,
    input  logic                            de_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
    output logic                            de_o,
    output logic                            hs_o,
    output logic                            vs_o,
    output logic [1:0]                      err_o
);

    localparam int DW       = CH_COUNT * PIXEL_WIDTH;
    localparam int ADDR_W   = $clog2(LINE_IN_SIZE_MAX);
    localparam int LS_SHIFT = $clog2(LINE_STEP);
    localparam int PROD_W   = PIXEL_WIDTH + COE_WIDTH;
    localparam int SUM_W    = PROD_W + 1;

    localparam logic [STEP_WIDTH-1:0]  LINE_STEP_S = STEP_WIDTH'(LINE_STEP);
    localparam logic [STEP_WIDTH:0]    LINE_STEP_X = (STEP_WIDTH + 1)'(LINE_STEP);
    localparam logic [COE_WIDTH-1:0]   LINE_STEP_C = COE_WIDTH'(LINE_STEP);
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX     = {PIXEL_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

    // Round-to-nearest of the weighted sum, clamped to the pixel range.
    function automatic logic [PIXEL_WIDTH-1:0] round_sat(input logic [PROD_W-1:0] a,
                                                         input logic [PROD_W-1:0] b);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] q;
        sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(LINE_STEP / 2);
        q   = sum >> LS_SHIFT;
        if (q > SUM_W'(PIX_MAX)) begin
            return PIX_MAX;
        end else begin
            return q[PIXEL_WIDTH-1:0];
        end
    endfunction

    state_t                  state_r;
    logic [STEP_WIDTH-1:0]   frac_r;
    logic                    line_emit_r;
    logic [COE_WIDTH-1:0]    line_coe_r;
    logic [15:0]             x_r;
    logic [15:0]             size_r;
    logic [STEP_WIDTH-1:0]   step_r;
    logic                    bypass_r;
    logic                    vs_pend_r;
    logic [1:0]              err_r;

    logic                    frame_start_s;
    logic [STEP_WIDTH-1:0]   step_in_s;
    logic [STEP_WIDTH:0]     frac_adv_s;
    logic                    hs_take_s;
    logic                    next_emit_s;
    logic [COE_WIDTH-1:0]    next_coe_s;
    logic [STEP_WIDTH-1:0]   next_frac_s;
    logic                    de_take_s;
    logic                    in_range_s;
    logic                    we_s;
    logic                    ovr_s;
    logic                    vs_entry_s;
    logic [ADDR_W-1:0]       addr_s;

    logic [DW-1:0]           line_ram [LINE_IN_SIZE_MAX];
    logic [DW-1:0]           rd_q;

    logic                    v1_r, v2_r, v3_r;
    logic                    hs1_r, hs2_r, hs3_r;
    logic                    vs1_r, vs2_r, vs3_r;
    logic [DW-1:0]           cur1_r, cur2_r, prev2_r;
    logic [COE_WIDTH-1:0]    coe1_r, coe2_r;
    logic [PROD_W-1:0]       prod_prev_r [CH_COUNT];
    logic [PROD_W-1:0]       prod_cur_r  [CH_COUNT];

    // Line-start decisions: next line's emit flag, blend coefficient and fraction.
    always_comb begin
        frame_start_s = hs_i & vs_i;
        step_in_s     = (scale_step < LINE_STEP_S) ? LINE_STEP_S : scale_step;
        frac_adv_s    = {1'b0, frac_r}
                      + (line_emit_r ? {1'b0, step_r} : {(STEP_WIDTH + 1){1'b0}})
                      - LINE_STEP_X;
        hs_take_s     = 1'b0;
        next_emit_s   = line_emit_r;
        next_coe_s    = line_coe_r;
        next_frac_s   = frac_r;
        if (frame_start_s) begin
            hs_take_s   = 1'b1;
            next_emit_s = bypass_i;
            next_coe_s  = LINE_STEP_C;
            next_frac_s = {STEP_WIDTH{1'b0}};
        end else if (hs_i && state_r == ST_FIRST) begin
            hs_take_s   = 1'b1;
            next_emit_s = 1'b1;
            next_coe_s  = bypass_r ? LINE_STEP_C : {COE_WIDTH{1'b0}};
            next_frac_s = {STEP_WIDTH{1'b0}};
        end else if (hs_i && state_r == ST_LINE) begin
            hs_take_s = 1'b1;
            if (bypass_r) begin
                next_emit_s = 1'b1;
                next_coe_s  = LINE_STEP_C;
                next_frac_s = {STEP_WIDTH{1'b0}};
            end else begin
                next_emit_s = (frac_adv_s < LINE_STEP_X);
                next_coe_s  = frac_adv_s[COE_WIDTH-1:0];
                next_frac_s = frac_adv_s[STEP_WIDTH-1:0];
            end
        end else begin
            hs_take_s = 1'b0;
        end
    end

    // Beat acceptance: beats past the latched line size are dropped and flagged.
    always_comb begin
        de_take_s  = de_i & ~hs_i & (state_r != ST_IDLE);
        in_range_s = (x_r <= size_r) && ({1'b0, x_r} < 17'(LINE_IN_SIZE_MAX));
        we_s       = de_take_s & in_range_s;
        ovr_s      = de_take_s & ~in_range_s;
        vs_entry_s = hs_take_s & next_emit_s & (frame_start_s | vs_pend_r);
        addr_s     = x_r[ADDR_W-1:0];
    end

    // Frame/line state machine with configuration latch and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            frac_r      <= {STEP_WIDTH{1'b0}};
            line_emit_r <= 1'b0;
            line_coe_r  <= {COE_WIDTH{1'b0}};
            x_r         <= 16'd0;
            size_r      <= 16'd0;
            step_r      <= LINE_STEP_S;
            bypass_r    <= 1'b0;
            vs_pend_r   <= 1'b0;
            err_r       <= 2'b00;
        end else begin
            if (frame_start_s) begin
                state_r   <= ST_FIRST;
                size_r    <= line_in_size;
                step_r    <= step_in_s;
                bypass_r  <= bypass_i;
                vs_pend_r <= ~bypass_i;
                err_r     <= {1'b0, (scale_step < LINE_STEP_S)};
            end else begin
                if (hs_take_s) begin
                    state_r <= ST_LINE;
                end else begin
                    state_r <= state_r;
                end
                if (hs_take_s && next_emit_s) begin
                    vs_pend_r <= 1'b0;
                end else begin
                    vs_pend_r <= vs_pend_r;
                end
                err_r <= err_r | {ovr_s, 1'b0};
            end
            if (hs_take_s) begin
                frac_r      <= next_frac_s;
                line_emit_r <= next_emit_s;
                line_coe_r  <= next_coe_s;
                x_r         <= 16'd0;
            end else if (de_take_s && x_r != 16'hFFFF) begin
                x_r <= x_r + 16'd1;
            end else begin
                x_r <= x_r;
            end
        end
    end

    // Read-first line buffer: the previous line's pixel comes out as the new one goes in.
    always_ff @(posedge clk) begin
        if (we_s) begin
            line_ram[addr_s] <= di_i;
        end
        rd_q <= line_ram[addr_s];
    end

    // Four-stage datapath: read, RAM data, multiply, round/saturate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;  v2_r  <= 1'b0;  v3_r  <= 1'b0;
            hs1_r   <= 1'b0;  hs2_r <= 1'b0;  hs3_r <= 1'b0;
            vs1_r   <= 1'b0;  vs2_r <= 1'b0;  vs3_r <= 1'b0;
            cur1_r  <= {DW{1'b0}};
            cur2_r  <= {DW{1'b0}};
            prev2_r <= {DW{1'b0}};
            coe1_r  <= {COE_WIDTH{1'b0}};
            coe2_r  <= {COE_WIDTH{1'b0}};
            for (int c = 0; c < CH_COUNT; c++) begin
                prod_prev_r[c] <= {PROD_W{1'b0}};
                prod_cur_r[c]  <= {PROD_W{1'b0}};
            end
            do_o <= {DW{1'b0}};
            de_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            v1_r   <= we_s & line_emit_r;
            hs1_r  <= hs_take_s & next_emit_s;
            vs1_r  <= vs_entry_s;
            cur1_r <= di_i;
            coe1_r <= line_coe_r;

            v2_r    <= v1_r;
            hs2_r   <= hs1_r;
            vs2_r   <= vs1_r;
            cur2_r  <= cur1_r;
            prev2_r <= rd_q;
            coe2_r  <= coe1_r;

            v3_r  <= v2_r;
            hs3_r <= hs2_r;
            vs3_r <= vs2_r;
            for (int c = 0; c < CH_COUNT; c++) begin
                prod_prev_r[c] <= PROD_W'(prev2_r[c*PIXEL_WIDTH +: PIXEL_WIDTH])
                                * PROD_W'(LINE_STEP_C - coe2_r);
                prod_cur_r[c]  <= PROD_W'(cur2_r[c*PIXEL_WIDTH +: PIXEL_WIDTH])
                                * PROD_W'(coe2_r);
            end

            de_o <= v3_r;
            hs_o <= hs3_r;
            vs_o <= vs3_r;
            for (int c = 0; c < CH_COUNT; c++) begin
                do_o[c*PIXEL_WIDTH +: PIXEL_WIDTH] <= v3_r ? round_sat(prod_prev_r[c], prod_cur_r[c])
                                                           : {PIXEL_WIDTH{1'b0}};
            end
        end
    end

    assign err_o = err_r;

endmodule

// File: tb/tb_scaler_v_mc.sv
// Randomised scoreboard bench for scaler_v_mc: a line-position model predicts
// every output beat and line start with its exact cycle; a monitor checks them.
module tb_scaler_v_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] line_in_size = 16'd0;
    logic [15:0] scale_step = 16'd128;
    logic        bypass_i = 1'b0;
    logic [23:0] di_i = 24'd0;
    logic        de_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [23:0] do_o;
    logic        de_o, hs_o, vs_o;
    logic [1:0]  err_o;

    scaler_v_mc #(
        .LINE_IN_SIZE_MAX(1024), .LINE_STEP(128), .PIXEL_WIDTH(8),
        .CH_COUNT(3), .COE_WIDTH(8), .STEP_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_in_size(line_in_size), .scale_step(scale_step),
        .bypass_i(bypass_i), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [23:0] data; } beat_t;
    typedef struct { int cyc; logic vs; } line_t;
    beat_t beat_q[$];
    line_t line_q[$];
    beat_t mb;
    line_t ml;
    int total = 0;
    int bad = 0;
    logic [23:0] img [0:15][0:15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every presented beat / line start must match the head of its queue.
    always @(negedge clk) begin
        if (de_o) begin
            if (beat_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_beat: got do_o=%h at cyc %0d, want no beat", do_o, cyc);
            end else begin
                mb = beat_q.pop_front();
                chk("beat_cyc", cyc, mb.cyc);
                chk("beat_data", {8'd0, do_o}, {8'd0, mb.data});
            end
        end
        if (hs_o) begin
            if (line_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_hs: got hs_o at cyc %0d, want none", cyc);
            end else begin
                ml = line_q.pop_front();
                chk("hs_cyc", cyc, ml.cyc);
                chk("vs_flag", {31'd0, vs_o}, {31'd0, ml.vs});
            end
        end else if (vs_o) begin
            total++; bad++;
            $display("FAIL vs_alone: got vs_o without hs_o at cyc %0d, want none", cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [23:0] blend(input logic [23:0] p, input logic [23:0] c, input int coe);
        logic [23:0] r;
        for (int ch = 0; ch < 3; ch++) begin
            int v;
            v = (int'(p[ch*8 +: 8]) * (128 - coe) + int'(c[ch*8 +: 8]) * coe + 64) / 128;
            if (v > 255) v = 255;
            r[ch*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_do"}, {8'd0, do_o}, 32'd0);
        chk({tag, "_de"}, {31'd0, de_o}, 32'd0);
        chk({tag, "_hs"}, {31'd0, hs_o}, 32'd0);
        chk({tag, "_vs"}, {31'd0, vs_o}, 32'd0);
        chk({tag, "_err"}, {30'd0, err_o}, 32'd0);
    endtask

    // One frame of h lines x w beats; gap: 0 dense, 1 every other clk, 2 random.
    task automatic run_frame(input int h, input int w, input int step, input bit byp,
                             input int size, input int gap, input int pat, input int rst_line);
        bit emit_l [16];
        int coe_l [16];
        bit live;
        bit first_out;
        int eff, p, n, r;
        for (int y = 0; y < h; y++) begin
            r = $urandom_range(0, 255);
            for (int x = 0; x < w; x++) begin
                case (pat)
                    0: img[y][x] = {3{8'((y << 4) | (x + 1))}};
                    1: img[y][x] = {8'(r), 8'(200 - 16 * y), 8'(16 * y)};
                    default: img[y][x] = 24'($urandom);
                endcase
            end
        end
        // Output k sits at position k*step between lines p/128 and p/128+1.
        for (int i = 0; i < 16; i++) begin emit_l[i] = 1'b0; coe_l[i] = 0; end
        eff = (step < 128) ? 128 : step;
        if (byp) begin
            for (int y = 0; y < h; y++) emit_l[y] = 1'b1;
        end else begin
            p = 0;
            n = 1;
            while (n <= h - 1) begin
                emit_l[n] = 1'b1;
                coe_l[n] = p % 128;
                p = p + eff;
                n = p / 128 + 1;
            end
        end
        live = 1'b1;
        first_out = 1'b1;
        for (int y = 0; y < h; y++) begin
            hs_i = 1'b1; vs_i = (y == 0); de_i = 1'b0;
            if (y == 0) begin
                line_in_size = 16'(size); scale_step = 16'(step); bypass_i = byp;
            end
            if (live && emit_l[y]) begin
                line_q.push_back('{cyc: cyc + 4, vs: first_out});
                first_out = 1'b0;
            end
            tick();
            hs_i = 1'b0; vs_i = 1'b0;
            if (y == 0) begin
                chk("err_at_vs", {30'd0, err_o}, {30'd0, 1'b0, (step < 128)});
                line_in_size = 16'($urandom_range(0, 2));
                scale_step = 16'($urandom);
                bypass_i = ~byp;
            end
            tick();
            for (int x = 0; x < w; x++) begin
                de_i = 1'b1;
                di_i = img[y][x];
                if (live && emit_l[y] && x <= size) begin
                    if (byp) beat_q.push_back('{cyc: cyc + 4, data: img[y][x]});
                    else beat_q.push_back('{cyc: cyc + 4, data: blend(img[y-1][x], img[y][x], coe_l[y])});
                end
                if (y == rst_line && x == 2) begin
                    rst_n = 1'b0;
                    tick();
                    chk_outputs_zero("mid_rst");
                    beat_q.delete();
                    line_q.delete();
                    de_i = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    live = 1'b0;
                end else begin
                    tick();
                end
                if (gap == 1) idle(1);
                else if (gap == 2) idle($urandom_range(0, 2));
            end
            idle(3);
        end
        idle(6);
        if (live) chk("err_end", {30'd0, err_o}, {30'd0, (w - 1 > size), (step < 128)});
        else chk("err_end_abort", {30'd0, err_o}, 32'd0);
    endtask

    initial begin
        int h, w, st, sz;
        bit bp;
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);
        run_frame(8, 8, 128, 1'b0, 7, 0, 0, -1);
        run_frame(8, 8, 256, 1'b0, 7, 0, 0, -1);
        run_frame(8, 8, 192, 1'b0, 7, 0, 1, -1);
        run_frame(8, 8, 128, 1'b1, 7, 1, 0, -1);
        run_frame(8, 6, 128, 1'b0, 3, 0, 2, -1);
        run_frame(8, 8, 64, 1'b0, 7, 0, 0, -1);
        run_frame(8, 8, 128, 1'b0, 7, 0, 0, 3);
        run_frame(8, 8, 128, 1'b0, 7, 0, 0, -1);
        run_frame(1, 8, 128, 1'b0, 7, 0, 2, -1);
        for (int i = 0; i < 6; i++) begin
            h  = $urandom_range(1, 10);
            w  = $urandom_range(1, 12);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(32, 127) : $urandom_range(128, 400);
            bp = ($urandom_range(0, 3) == 0);
            sz = ($urandom_range(0, 2) == 0) ? $urandom_range(0, w) : w - 1;
            run_frame(h, w, st, bp, sz, $urandom_range(0, 2), 2, -1);
        end
        idle(10);
        chk("beats_left", beat_q.size(), 32'd0);
        chk("lines_left", line_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scaler_v_mc.md
Name: scaler_v_mc

Overview:
- Next-generation vertical linear down-scaler for the video pipeline.
- Accepts CH_COUNT pixel channels per beat and buffers one line in block RAM.
- Emits each output line as a linear blend of two adjacent input lines, streamed alongside the later input line at fixed latency.
- Adds over the previous scaler_v: per-beat multi-channel data, a runtime bypass, synchronous reset, frame-latched configuration, and sticky error flags for configuration and line overrun.

Parameters:
- LINE_IN_SIZE_MAX, 1024: line buffer depth in beats.
- LINE_STEP, 128: fixed-point value of 1.0 line. Must be a power of 2.
- PIXEL_WIDTH, 8: bits per channel.
- CH_COUNT, 3: channels per beat. Range 1..4.
- COE_WIDTH, 8: coefficient width. Must be ≥ clog2(LINE_STEP)+1.
- STEP_WIDTH, 16: width of scale_step and of the internal fraction accumulator.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: synchronous active-low reset, sampled on rising clk.
- line_in_size, in, 16: pixels per input line minus 1.
- scale_step, in, STEP_WIDTH: input-line advance per output line, in LINE_STEP units. Value ≥ LINE_STEP.
- bypass_i, in, 1: 1 passes data through unscaled.
- di_i, in, CH_COUNT*PIXEL_WIDTH: pixel beat, channel c at bits [c*PIXEL_WIDTH +: PIXEL_WIDTH].
- de_i, in, 1: beat valid.
- hs_i, in, 1: one-cycle line-start pulse, before the first de_i of a line.
- vs_i, in, 1: one-cycle frame-start pulse, coincident with the hs_i of line 0.
- do_o, out, CH_COUNT*PIXEL_WIDTH: output beat.
- de_o, out, 1: output valid.
- hs_o, out, 1: output line-start pulse.
- vs_o, out, 1: output frame-start pulse.
- err_o, out, 2: sticky flags. Bit0 = config error, bit1 = line overrun.

Behaviour:
- Reset:
  - Outputs do_o, de_o, hs_o, vs_o and err_o are all 0.
  - Fraction accumulator (frac), line index and pipeline are cleared.
  - State is IDLE. RAM contents are not cleared.
  - Reset mid-frame aborts the frame; nothing is emitted until the next vs_i.
- Configuration latch:
  - line_in_size, scale_step and bypass_i are latched on each vs_i&hs_i.
  - Changes mid-frame have no effect.
  - If latched scale_step < LINE_STEP: use LINE_STEP and set err_o[0].
- Error clearing: err_o bits clear on the next vs_i.
- State machine:
  - IDLE: hs_i&vs_i -> FIRST. Any other hs_i or de_i is ignored.
  - FIRST (input line 0): write the line to RAM only, no output. Next hs_i -> LINE. frac=0.
  - LINE (input line n≥1): on hs_i decide emit = (frac < LINE_STEP) and coe = frac.
    - Each de_i beat at x: read prev[x] from RAM, then write cur[x] (read-before-write, same address).
    - If emit: each channel output = (prev*(LINE_STEP-coe) + cur*coe + LINE_STEP/2) >> log2(LINE_STEP).
    - Result is saturated to PIXEL_WIDTH.
    - At the following hs_i: frac = (emit ? frac+scale_step : frac) - LINE_STEP, then re-evaluate emit.
    - vs_i&hs_i in LINE restarts the frame (-> FIRST).
- Bypass:
  - Every input line is output unchanged, in both FIRST and LINE.
  - RAM is still written.
- Latency:
  - de_o/do_o lag de_i by exactly 4 clk (RAM read, RAM data, multiply, sum/round+saturate). The same applies in bypass.
  - hs_o lags hs_i by 4 clk, and only on emitted lines.
  - vs_o is asserted with the first hs_o of each frame.
  - de_o is only asserted on emitted lines.
- Gaps: de_i gaps (sparse input) are preserved one-to-one at the output.
- Overrun: beats with x > latched line_in_size are dropped (no RAM write, no de_o) and set err_o[1].
- Short lines: the unused tail keeps stale RAM data and is never output.
- Output line count:
  - Per frame of H lines: number of n in 1..H-1 for which emit holds.
  - H=1: no output.
- Arithmetic: products are PIXEL_WIDTH+COE_WIDTH bits; the sum is one bit wider. No wrap is allowed.

Test Plan:
- LINE_STEP=128, scale_step=128, 8x8 frame, pixel=(y<<4)|(x+1), CH_COUNT=1 -> 7 output lines equal to input lines 0..6; de_o exactly 4 clk after the de_i of input lines 1..7.
- scale_step=256, same frame -> 4 output lines equal to input lines 0,2,4,6; vs_o coincident with the first hs_o only.
- scale_step=192, input line y constant value 16*y, CH_COUNT=3 with independent channel values -> output lines: coe 0 on line 1 = 0; coe 64 on line 2 = 24; coe 0 on line 4 = 48; coe 64 on line 5 = 72; ... Channels are blended independently.
- bypass_i=1 -> 8 lines identical to input at 4 clk latency. Run with DE gaps (1 valid per 2 clk) and confirm identical gap pattern.
- line_in_size=3 with 6-beat lines -> 4 beats per output line and err_o[1]=1 until the next vs_i. scale_step=64 -> err_o[0]=1 and behaviour identical to scale_step=128.
- rst_n low for 2 clk mid-line 3 -> all outputs 0 next clk; no output until a new vs_i. The following frame is correct per scenario 1.
